// File: rtl/data_ram.sv
// Word-addressed data memory with combinational read and a single-cycle synchronous clear.
// Storage lives in flops: the async read and whole-array clear rule out block RAM.
module data_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [15:0]       DataAddress,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut
);

  localparam int          ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  // Declaration initialiser gives the all-zero power-up image.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;

  // Full-width compare so upper address bits never alias onto low words.
  assign w_in_range = ({1'b0, DataAddress} < DEPTH_L);
  assign w_idx      = DataAddress[ADDR_W-1:0];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (MemWrite && w_in_range) begin
      r_mem[w_idx] <= DataIn;
    end
  end

  assign DataOut = w_in_range ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: reset, write/read, out-of-range, reset priority, boundaries.
module tb_data_ram;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] DataAddress = '0;
  logic        MemWrite = 1'b0;
  logic [15:0] DataIn = '0;
  logic [15:0] DataOut;

  int n_checks = 0;
  int n_pass   = 0;

  data_ram #(.DATA_W(16), .DEPTH(256)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .DataAddress(DataAddress),
    .MemWrite   (MemWrite),
    .DataIn     (DataIn),
    .DataOut    (DataOut)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%h", tag, got);
    end else begin
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    DataAddress = addr;
    #1;
    check(tag, DataOut, exp);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    DataAddress = addr;
    DataIn      = data;
    MemWrite    = 1'b1;
    tick();
    MemWrite    = 1'b0;
  endtask

  logic [15:0] acc;

  initial begin
    #1;
    rd("powerup_addr0", 16'd0, 16'h0000);
    rd("powerup_addr255", 16'd255, 16'h0000);

    // write then read
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    rd("after_reset_addr1", 16'd1, 16'h0000);
    DataAddress = 16'd1;
    DataIn      = 16'hFFFF;
    MemWrite    = 1'b1;
    #1;
    check("no_write_through", DataOut, 16'h0000);
    tick();
    check("same_cycle_new", DataOut, 16'hFFFF);
    MemWrite = 1'b0;
    rd("wr_rd_addr32", 16'd32, 16'h0000);
    rd("wr_rd_addr1", 16'd1, 16'hFFFF);

    // write disabled
    DataAddress = 16'd5;
    DataIn      = 16'h1234;
    MemWrite    = 1'b0;
    repeat (3) tick();
    rd("wr_disabled_addr5", 16'd5, 16'h0000);

    // out of range
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    wr(16'd300, 16'hABCD);
    rd("oor_read_300", 16'd300, 16'h0000);
    rd("oor_alias_44", 16'd44, 16'h0000);
    rd("oor_read_ffff", 16'hFFFF, 16'h0000);
    acc = '0;
    for (int a = 0; a < 256; a++) begin
      DataAddress = 16'(a);
      #1;
      acc |= DataOut;
    end
    check("oor_all_words_zero", acc, 16'h0000);

    // reset clears and beats a write
    wr(16'd7, 16'h5A5A);
    wr(16'd255, 16'h00FF);
    rd("pre_rst_addr7", 16'd7, 16'h5A5A);
    rd("pre_rst_addr255", 16'd255, 16'h00FF);
    Reset       = 1'b1;
    MemWrite    = 1'b1;
    DataAddress = 16'd7;
    DataIn      = 16'h1111;
    #1;
    check("rst_between_edges", DataOut, 16'h5A5A);
    tick();
    MemWrite = 1'b0;
    rd("rst_addr7", 16'd7, 16'h0000);
    rd("rst_addr255", 16'd255, 16'h0000);
    tick();
    rd("rst_held_addr100", 16'd100, 16'h0000);
    Reset = 1'b0;

    // last write wins, async read
    DataAddress = 16'd10;
    DataIn      = 16'h0001;
    MemWrite    = 1'b1;
    tick();
    check("b2b_first", DataOut, 16'h0001);
    DataIn = 16'h0002;
    tick();
    MemWrite = 1'b0;
    rd("b2b_addr3", 16'd3, 16'h0000);
    rd("b2b_async_addr10", 16'd10, 16'h0002);
    rd("b2b_neighbor11", 16'd11, 16'h0000);

    // boundaries
    wr(16'd0, 16'h8001);
    wr(16'd255, 16'h7FFE);
    rd("bnd_addr0", 16'd0, 16'h8001);
    rd("bnd_addr255", 16'd255, 16'h7FFE);
    rd("bnd_addr1", 16'd1, 16'h0000);
    rd("bnd_addr254", 16'd254, 16'h0000);
    rd("bnd_addr256", 16'd256, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
